// File: rtl/traffic_light_monitor.sv
// Independent protocol checker for the intersection lamp outputs: legal patterns,
// fixed phase order and per-phase dwell, with a sticky first-cause fault.
module traffic_light_monitor #(
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ns_g,
    input  logic       ns_y,
    input  logic       ns_r,
    input  logic       ew_g,
    input  logic       ew_y,
    input  logic       ew_r,
    output logic       locked,
    output logic [1:0] phase,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] cycle_count
);

    // state  | meaning
    // SYNC   | waiting for the first NS_GREEN sample after reset
    // LOCKED | tracking phase order and dwell of each phase
    // FAULT  | first violation latched; only reset leaves

    localparam int MAX_TICKS = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 2);

    localparam logic [CW-1:0] GREEN_CNT  = CW'(GREEN_TICKS);
    localparam logic [CW-1:0] YELLOW_CNT = CW'(YELLOW_TICKS);

    localparam logic [1:0] PH_NS_GREEN  = 2'b00;
    localparam logic [1:0] PH_NS_YELLOW = 2'b01;
    localparam logic [1:0] PH_EW_GREEN  = 2'b10;
    localparam logic [1:0] PH_EW_YELLOW = 2'b11;

    localparam logic [2:0] FC_ILLEGAL  = 3'd1;
    localparam logic [2:0] FC_SEQUENCE = 3'd2;
    localparam logic [2:0] FC_SHORT    = 3'd3;
    localparam logic [2:0] FC_LONG     = 3'd4;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t        state_q;
    logic [1:0]    phase_q;
    logic [CW-1:0] remain_q;
    logic          locked_q;
    logic          fault_q;
    logic [2:0]    code_q;
    logic [7:0]    cycles_q;

    logic [5:0]    lamps;
    logic          obs_legal;
    logic [1:0]    obs_phase;
    logic [1:0]    succ_phase;
    logic [CW-1:0] tick_ext;
    logic [CW-1:0] load_cnt;

    assign lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};

    always_comb begin
        obs_legal = 1'b1;
        obs_phase = PH_NS_GREEN;
        case (lamps)
            6'b100_001: obs_phase = PH_NS_GREEN;
            6'b010_001: obs_phase = PH_NS_YELLOW;
            6'b001_100: obs_phase = PH_EW_GREEN;
            6'b001_010: obs_phase = PH_EW_YELLOW;
            default:    obs_legal = 1'b0;
        endcase
    end

    assign succ_phase = phase_q + 2'd1;
    assign tick_ext   = CW'(tick);

    // Dwell is a down-counter of ticks still owed; a tick in the entry cycle
    // already belongs to the new phase.
    assign load_cnt = (obs_phase[0] ? YELLOW_CNT : GREEN_CNT) - tick_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_SYNC;
            phase_q  <= PH_NS_GREEN;
            remain_q <= '0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= 3'd0;
            cycles_q <= 8'd0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (!obs_legal) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                        code_q  <= FC_ILLEGAL;
                    end else if (obs_phase == PH_NS_GREEN) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                        phase_q  <= PH_NS_GREEN;
                        remain_q <= load_cnt;
                    end
                end
                ST_LOCKED: begin
                    if (!obs_legal) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                        code_q  <= FC_ILLEGAL;
                    end else if (obs_phase == phase_q) begin
                        if (remain_q == '0) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                            code_q  <= FC_LONG;
                        end else begin
                            remain_q <= remain_q - tick_ext;
                        end
                    end else if (obs_phase != succ_phase) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                        code_q  <= FC_SEQUENCE;
                    end else if (remain_q != '0) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                        code_q  <= FC_SHORT;
                    end else begin
                        phase_q  <= obs_phase;
                        remain_q <= load_cnt;
                        if (phase_q == PH_EW_YELLOW) begin
                            cycles_q <= cycles_q + 8'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    state_q <= ST_FAULT;
                end
                default: begin
                    state_q <= ST_SYNC;
                end
            endcase
        end
    end

    assign locked      = locked_q;
    assign phase       = phase_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign cycle_count = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed lamp sequences push expected
// outputs per clock; a separate monitor pops and compares after each edge.
module tb_traffic_light_monitor;

    localparam logic [5:0] L_NSG = 6'b100001;
    localparam logic [5:0] L_NSY = 6'b010001;
    localparam logic [5:0] L_EWG = 6'b001100;
    localparam logic [5:0] L_EWY = 6'b001010;
    localparam logic [5:0] L_OFF = 6'b000000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       ns_g = 1'b0, ns_y = 1'b0, ns_r = 1'b0;
    logic       ew_g = 1'b0, ew_y = 1'b0, ew_r = 1'b0;
    logic       locked;
    logic [1:0] phase;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] cycle_count;

    traffic_light_monitor #(.GREEN_TICKS(5), .YELLOW_TICKS(2)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
        .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
        .locked(locked), .phase(phase), .fault(fault),
        .fault_code(fault_code), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         tag;
        logic       locked;
        logic [1:0] phase;
        logic       fault;
        logic [2:0] code;
        logic [7:0] cc;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    event  async_chk;
    int    n_tests = 0;
    int    n_fail  = 0;

    logic       exp_locked = 1'b0;
    logic [1:0] exp_phase  = 2'd0;
    logic       exp_fault  = 1'b0;
    logic [2:0] exp_code   = 3'd0;
    logic [7:0] exp_cc     = 8'd0;

    function automatic logic [5:0] lamps_of(input logic [1:0] p);
        case (p)
            2'd0:    return L_NSG;
            2'd1:    return L_NSY;
            2'd2:    return L_EWG;
            default: return L_EWY;
        endcase
    endfunction

    task automatic push_exp(input int tag, input string nm);
        exp_t e;
        e.tag = tag; e.locked = exp_locked; e.phase = exp_phase;
        e.fault = exp_fault; e.code = exp_code; e.cc = exp_cc;
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic set_exp(input logic l, input logic [1:0] p, input logic f, input logic [2:0] c);
        exp_locked = l; exp_phase = p; exp_fault = f; exp_code = c;
    endtask

    // Called at a falling edge: drive lamps for the next rising edge and record
    // the outputs expected right after that edge.
    task automatic drive(input logic [5:0] lamps, input logic t, input string nm);
        {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = lamps;
        tick = t;
        push_exp(cyc + 1, nm);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        #1 rst = 1'b0;
        exp_cc = 8'd0;
        set_exp(1'b0, 2'd0, 1'b0, 3'd0);
        drive(L_NSG, 1'b1, "reset");
        rst = 1'b1;
    endtask

    task automatic nsg_ticks(input int n, input string nm);
        set_exp(1'b1, 2'd0, 1'b0, 3'd0);
        repeat (n) drive(L_NSG, 1'b1, nm);
    endtask

    // Behavioural intersection controller: green 5 ticks, yellow 2 ticks,
    // phase advances on the tick that completes the phase.
    task automatic run_ctrl(input int ncyc, input int tper, input string nm);
        logic [1:0] cp;
        logic [1:0] prev;
        logic       t;
        int         ct;
        int         k;
        int         done;
        cp = 2'd0; prev = 2'd0; ct = 0; k = 0; done = 0;
        exp_locked = 1'b1; exp_fault = 1'b0; exp_code = 3'd0;
        while (done < ncyc) begin
            t = ((k % tper) == (tper - 1));
            if (cp == 2'd0 && prev == 2'd3) begin
                exp_cc = exp_cc + 8'd1;
                done++;
            end
            exp_phase = cp;
            drive(lamps_of(cp), t, nm);
            prev = cp;
            if (t) begin
                ct++;
                if (ct == (cp[0] ? 2 : 5)) begin
                    cp = cp + 2'd1;
                    ct = 0;
                end
            end
            k++;
        end
    endtask

    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk or async_chk);
            while (sb_q.size() > 0 && sb_q[0].tag <= cyc) begin
                e  = sb_q.pop_front();
                nm = nm_q.pop_front();
                n_tests++;
                if (locked !== e.locked || phase !== e.phase || fault !== e.fault ||
                    fault_code !== e.code || cycle_count !== e.cc) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got locked=%b phase=%b fault=%b code=%0d cc=%0d, want locked=%b phase=%b fault=%b code=%0d cc=%0d",
                             nm, cyc, locked, phase, fault, fault_code, cycle_count,
                             e.locked, e.phase, e.fault, e.code, e.cc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        set_exp(1'b0, 2'd0, 1'b0, 3'd0);
        drive(L_NSG, 1'b1, "reset_hold");
        drive(L_NSG, 1'b0, "reset_hold");
        rst = 1'b1;

        run_ctrl(3, 4, "normal_tick4");
        n_tests++;
        if (cycle_count !== 8'd3 || fault !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL normal_end: cc=%0d fault=%b locked=%b, want cc=3 fault=0 locked=1",
                     cycle_count, fault, locked);
        end

        reset_dut();
        set_exp(1'b1, 2'd0, 1'b0, 3'd0);
        drive(L_NSG, 1'b1, "ill_pre");
        drive(L_NSG, 1'b0, "ill_pre");
        set_exp(1'b1, 2'd0, 1'b1, 3'd1);
        drive(L_OFF, 1'b0, "ill_fault");
        drive(L_NSG, 1'b1, "ill_sticky");
        drive(L_NSY, 1'b1, "ill_sticky");
        drive(L_EWG, 1'b0, "ill_sticky");
        n_tests++;
        if (fault !== 1'b1 || fault_code !== 3'd1 || phase !== 2'd0) begin
            n_fail++;
            $display("FAIL ill_end: fault=%b code=%0d phase=%b, want fault=1 code=1 phase=00",
                     fault, fault_code, phase);
        end

        reset_dut();
        nsg_ticks(5, "seq_pre");
        set_exp(1'b1, 2'd0, 1'b1, 3'd2);
        drive(L_EWG, 1'b0, "seq_fault");
        drive(L_NSY, 1'b1, "seq_sticky");
        n_tests++;
        if (fault_code !== 3'd2) begin
            n_fail++;
            $display("FAIL seq_end: code=%0d, want 2", fault_code);
        end

        reset_dut();
        nsg_ticks(4, "short_pre");
        set_exp(1'b1, 2'd0, 1'b1, 3'd3);
        drive(L_NSY, 1'b0, "short_fault");
        drive(L_NSY, 1'b1, "short_sticky");

        reset_dut();
        nsg_ticks(5, "long_pre");
        set_exp(1'b1, 2'd0, 1'b1, 3'd4);
        drive(L_NSG, 1'b0, "long_fault");
        drive(L_NSY, 1'b0, "long_sticky");

        reset_dut();
        nsg_ticks(5, "combo_pre");
        set_exp(1'b1, 2'd0, 1'b1, 3'd1);
        drive(6'b101100, 1'b0, "combo_fault");
        drive(L_NSY, 1'b0, "combo_sticky");

        reset_dut();
        nsg_ticks(5, "ylong_pre");
        set_exp(1'b1, 2'd1, 1'b0, 3'd0);
        drive(L_NSY, 1'b1, "ylong_accept");
        drive(L_NSY, 1'b1, "ylong_dwell");
        set_exp(1'b1, 2'd1, 1'b1, 3'd4);
        drive(L_NSY, 1'b0, "ylong_fault");

        reset_dut();
        set_exp(1'b0, 2'd0, 1'b0, 3'd0);
        drive(L_EWY, 1'b1, "sync_ignore");
        set_exp(1'b0, 2'd0, 1'b1, 3'd1);
        drive(6'b111111, 1'b0, "sync_illegal");
        drive(L_NSG, 1'b0, "sync_ill_sticky");

        reset_dut();
        run_ctrl(256, 1, "wrap_tick1");
        n_tests++;
        if (cycle_count !== 8'd0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_end: cc=%0d fault=%b, want cc=0 fault=0", cycle_count, fault);
        end

        reset_dut();
        run_ctrl(2, 1, "pre_async");
        drive(L_NSG, 1'b1, "pre_async");
        drive(L_NSG, 1'b1, "pre_async");
        #1 rst = 1'b0;
        exp_cc = 8'd0;
        set_exp(1'b0, 2'd0, 1'b0, 3'd0);
        #1 push_exp(cyc, "async_rst");
        ->async_chk;
        drive(L_NSG, 1'b1, "rst_held");
        rst = 1'b1;
        drive(L_NSY, 1'b1, "relock_ignore");
        drive(L_EWG, 1'b0, "relock_ignore");
        set_exp(1'b1, 2'd0, 1'b0, 3'd0);
        drive(L_NSG, 1'b0, "relock");
        drive(L_NSG, 1'b1, "relock_hold");
        n_tests++;
        if (locked !== 1'b1 || cycle_count !== 8'd0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL relock_end: locked=%b cc=%0d fault=%b, want locked=1 cc=0 fault=0",
                     locked, cycle_count, fault);
        end

        @(negedge clk);
        #1;
        while (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unchecked %s: expectation tag=%0d never compared (cyc=%0d)",
                     nm_q[0], sb_q[0].tag, cyc);
            void'(sb_q.pop_front());
            void'(nm_q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
